// File: rtl/dma_apb_slave_bridge.sv
`default_nettype none
// ============================================================================
//  Module   : dma_apb_slave_bridge
//  Purpose  : APB3 slave bridging the DMA configuration port onto the DMA
//             register file, with programmable read wait states.
//  Options  : define DMA_APB_SLVERR_EN to flag misaligned/out-of-range
//             accesses with PSLVERR.
//  Revision : 1.0 - initial release
// ============================================================================
module dma_apb_slave_bridge #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 8,
  parameter int REG_NUM = 64,
  parameter int RD_LAT  = 1
) (
  input  logic                  i_clk,
  input  logic                  i_pnreset,
  input  logic                  i_psel,
  input  logic                  i_penable,
  input  logic [31:0]           i_paddr,
  input  logic                  i_pwrite,
  input  logic [DATA_W-1:0]     i_pwdata,
  output logic                  o_pready,
  output logic                  o_pslverr,
  output logic [DATA_W-1:0]     o_prdata,
  output logic [ADDR_W-1:0]     o_addr,
  output logic                  o_read_en,
  output logic                  o_write_en,
  output logic [DATA_W/8-1:0]   o_byte_strobe,
  output logic [DATA_W-1:0]     o_wdata,
  input  logic [DATA_W-1:0]     i_rdata
);

  localparam int c_BW = (DATA_W == 64) ? 3 : 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t              r_state, w_state_nxt;
  logic [3:0]          r_cnt, w_cnt_nxt;
  logic                r_err, w_err_nxt;
  logic [DATA_W-1:0]   r_prdata, w_prdata_nxt;
  logic                w_setup, w_err, w_read_en, w_write_en;

`ifdef DMA_APB_SLVERR_EN
  logic [31:0] w_index;
  assign w_index = {{c_BW{1'b0}}, i_paddr[31:c_BW]};
  assign w_err   = (i_paddr[c_BW-1:0] != '0) | (w_index >= 32'(REG_NUM));
`else
  // Upper address bits alias onto the register space when errors are off.
  logic w_unused_paddr;
  assign w_unused_paddr = ^i_paddr[31:ADDR_W];
  assign w_err          = 1'b0;
`endif

  // Reset gating keeps strobes quiet while the register file is held in reset.
  assign w_setup = i_psel & ~i_penable & (r_state == ST_IDLE) & i_pnreset;

  always_ff @(posedge i_clk or negedge i_pnreset) begin
    if (!i_pnreset) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_err    <= 1'b0;
      r_prdata <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_err    <= w_err_nxt;
      r_prdata <= w_prdata_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_err_nxt    = r_err;
    w_prdata_nxt = r_prdata;
    w_read_en    = 1'b0;
    w_write_en   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_setup) begin
          if (i_pwrite) begin
            w_write_en  = ~w_err;
            w_err_nxt   = w_err;
            w_state_nxt = ST_RESP;
          end else if (w_err) begin
            w_err_nxt    = 1'b1;
            w_prdata_nxt = '0;
            w_state_nxt  = ST_RESP;
          end else begin
            w_read_en   = 1'b1;
            w_err_nxt   = 1'b0;
            w_cnt_nxt   = 4'(RD_LAT);
            w_state_nxt = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        // A dropped select abandons the transfer before any data capture.
        if (!i_psel) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
          if (r_cnt == 4'd1) begin
            w_prdata_nxt = i_rdata;
            w_state_nxt  = ST_RESP;
          end
        end
      end
      ST_RESP: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign o_pready      = (r_state == ST_RESP);
  assign o_pslverr     = (r_state == ST_RESP) & r_err;
  assign o_prdata      = r_prdata;
  assign o_addr        = i_paddr[ADDR_W-1:0];
  assign o_read_en     = w_read_en;
  assign o_write_en    = w_write_en;
  assign o_byte_strobe = '1;
  assign o_wdata       = i_pwdata;

endmodule
`default_nettype wire
